// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - encodes A64 instruction requests into words and buffers them with sequential addresses
module insn_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_W     = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [25:0]       req_imm,
    input  logic [1:0]        req_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              err_illegal
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_HLT     = 4'd0;
    localparam logic [3:0] OP_CBZ     = 4'd1;
    localparam logic [3:0] OP_B       = 4'd2;
    localparam logic [3:0] OP_MOVZ    = 4'd3;
    localparam logic [3:0] OP_ADDI    = 4'd4;
    localparam logic [3:0] OP_SUBI    = 4'd5;
    localparam logic [3:0] OP_CMP     = 4'd6;
    localparam logic [3:0] OP_DECLOOP = 4'd7;

    typedef enum logic {IDLE, EMIT} stateType;

    stateType          state;
    logic [1:0]        wordIdx;
    logic [3:0]        capOp;
    logic [4:0]        capRd;
    logic [4:0]        capRn;
    logic [4:0]        capRm;
    logic [25:0]       capImm;
    logic [1:0]        capShift;

    logic [31:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  fifoCount;
    logic [ADDR_W-1:0] addrReg;
    logic              errReg;

    logic              accept;
    logic              illegal;
    logic              push;
    logic              pop;
    logic              lastWord;
    logic [31:0]       encWord;

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign illegal     = req_op[3];
    // A pop in the same cycle does not free a slot for the push.
    assign push        = (state == EMIT) && (fifoCount < CNT_W'(FIFO_DEPTH));
    assign pop         = out_valid && out_ready;
    assign lastWord    = (capOp == OP_DECLOOP) ? (wordIdx == 2'd2) : 1'b1;

    assign out_valid   = (fifoCount != '0);
    assign out_word    = fifoMem[rdPtr];
    assign out_addr    = addrReg;
    assign busy        = (state != IDLE) || (fifoCount != '0);
    assign err_illegal = errReg;

    always_comb begin
        encWord = '0;
        case (capOp)
            OP_HLT:  encWord = 32'hD440_0000 | {11'b0, capImm[15:0], 5'b0};
            OP_CBZ:  encWord = 32'hB400_0000 | {8'b0, capImm[18:0], capRd};
            OP_B:    encWord = 32'h1400_0000 | {6'b0, capImm};
            OP_MOVZ: encWord = 32'hD280_0000 | {9'b0, capShift, capImm[15:0], capRd};
            OP_ADDI: encWord = 32'h9100_0000 | {9'b0, capShift[0], capImm[11:0], capRn, capRd};
            OP_SUBI: encWord = 32'hD100_0000 | {9'b0, capShift[0], capImm[11:0], capRn, capRd};
            OP_CMP:  encWord = 32'hEB00_001F | {11'b0, capRm, capImm[5:0], capRn, 5'b0};
            OP_DECLOOP: begin
                // SUBI rd,rd,#1 ; CBZ rd,+2 ; B back to the loop target
                case (wordIdx)
                    2'd0:    encWord = 32'hD100_0000 | {10'b0, 12'd1, capRd, capRd};
                    2'd1:    encWord = 32'hB400_0000 | {8'b0, 19'd2, capRd};
                    default: encWord = 32'h1400_0000 | {6'b0, capImm - 26'd2};
                endcase
            end
            default: encWord = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifoMem[wrPtr] <= encWord;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wordIdx   <= '0;
            capOp     <= '0;
            capRd     <= '0;
            capRn     <= '0;
            capRm     <= '0;
            capImm    <= '0;
            capShift  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            addrReg   <= ADDR_W'(BASE_ADDR);
            errReg    <= 1'b0;
        end else begin
            errReg <= accept && illegal;
            case (state)
                IDLE: begin
                    if (accept && !illegal) begin
                        capOp    <= req_op;
                        capRd    <= req_rd;
                        capRn    <= req_rn;
                        capRm    <= req_rm;
                        capImm   <= req_imm;
                        capShift <= req_shift;
                        wordIdx  <= '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (push) begin
                        if (lastWord) begin
                            state <= IDLE;
                        end else begin
                            wordIdx <= wordIdx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr   <= rdPtr + 1'b1;
                addrReg <= addrReg + 1'b1;
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 1'b1;
            end
        end
    end
endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-002 Parameter ADDR_W, default 8, width of the output word address.
REQ-003 Parameter BASE_ADDR, default 0, first address issued after reset.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  encode request present.
REQ-007 req_ready  out  1  encoder accepts request this cycle.
REQ-008 req_op  in  4  0 HLT, 1 CBZ, 2 B, 3 MOVZ, 4 ADDI, 5 SUBI, 6 CMP(reg), 7 DECLOOP; 8-15 illegal.
REQ-009 req_rd, req_rn, req_rm  in  5 each  register fields.
REQ-010 req_imm  in  26  immediate/offset; low bits used per op.
REQ-011 req_shift  in  2  MOVZ hw; ADDI/SUBI sh = req_shift[0].
REQ-012 out_valid  out  1  out_word/out_addr valid.
REQ-013 out_ready  in  1  consumer (instruction memory writer) accepts word.
REQ-014 out_word  out  32  encoded A64 instruction.
REQ-015 out_addr  out  ADDR_W  word address of out_word.
REQ-016 busy  out  1  FSM not IDLE or FIFO non-empty.
REQ-017 err_illegal  out  1  one-cycle pulse on acceptance of illegal op.

Function
REQ-018 Encodings SHALL be: HLT 0xD4400000|imm[15:0]<<5; CBZ 0xB4000000|imm[18:0]<<5|rd; B 0x14000000|imm[25:0]; MOVZ 0xD2800000|shift<<21|imm[15:0]<<5|rd; ADDI 0x91000000|sh<<22|imm[11:0]<<10|rn<<5|rd; SUBI 0xD1000000|same fields; CMP 0xEB00001F|rm<<16|imm[5:0]<<10|rn<<5.
REQ-019 DECLOOP SHALL expand to three words in order: SUBI rd,rd,#1; CBZ rd,imm19=2; B imm26=(req_imm-2) mod 2^26.
REQ-020 FSM states SHALL be IDLE and EMIT; EMIT holds captured request and word index 0..2.
REQ-021 req_ready SHALL equal (state==IDLE) and not rst; handshake = req_valid&&req_ready.
REQ-022 On legal handshake: capture all req fields, index=0, go EMIT next edge.
REQ-023 On illegal handshake: request dropped, err_illegal=1 next cycle only, stay IDLE.
REQ-024 In EMIT, one word SHALL be pushed per cycle when FIFO count<FIFO_DEPTH (pop in same cycle not counted); otherwise stall, index held.
REQ-025 After pushing last word (index 0 single ops, index 2 DECLOOP) go IDLE next edge.
REQ-026 Latency: request accepted at edge N -> first word in FIFO and out_valid=1 after edge N+1 (FIFO empty, no stall).
REQ-027 FIFO SHALL be first-in-first-out; out_valid = count!=0; pop on out_valid&&out_ready; push and pop same cycle leave count unchanged.
REQ-028 out_word/out_addr SHALL be stable while out_valid&&!out_ready.
REQ-029 out_addr SHALL start at BASE_ADDR, increment by 1 on each pop, wrap modulo 2^ADDR_W.
REQ-030 Fields wider than used SHALL be ignored (upper imm bits masked).
REQ-031 Sustained throughput with out_ready=1: one word per cycle; one idle req_ready cycle between requests.

Reset
REQ-032 rst SHALL force: state IDLE, index 0, FIFO empty, out_valid=0, out_addr=BASE_ADDR, err_illegal=0, busy=0, req_ready=0 during rst.
REQ-033 rst mid-EMIT or with FIFO non-empty SHALL discard captured request and buffered words; no partial sequence resumes.
REQ-034 out_word value while out_valid=0 is don't-care.

Verification
REQ-035 MOVZ rd=3, imm=0x1234, shift=1, out_ready=1 -> out_word 0xD2A24683, out_addr 0, one word.
REQ-036 DECLOOP rd=2, imm=0 -> words 0xD1000442, 0xB4000042, 0x17FFFFFE at addrs 0,1,2 consecutive cycles.
REQ-037 out_ready=0, six CMP rn=1 rm=2 requests -> four buffered (0xEB02003F each), EMIT stalls, req_ready=0; release out_ready -> all six emitted in order, addrs 0-5.
REQ-038 req_op=9 -> no word, err_illegal one-cycle pulse, req_ready high next cycle.
REQ-039 rst asserted during DECLOOP after first push -> out_valid=0 next cycle, next HLT imm=0 appears at out_addr=BASE_ADDR as 0xD4400000.
REQ-040 ADDR_W=2, five B imm=1 requests -> out_addr 0,1,2,3,0; out_word 0x14000001.
